// File: rtl/tstate_int_sequencer_pkg.sv
// Shared encodings for the T-state / interrupt sequencer: mode, vector and source codes.
package tstate_int_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_FETCH  = 2'd0,
    MODE_EXEC   = 2'd1,
    MODE_INTSEQ = 2'd2
  } seqMode_t;

  typedef enum logic [1:0] {
    VEC_RST = 2'd0,
    VEC_NMI = 2'd1,
    VEC_IRQ = 2'd2
  } vecSel_t;

  typedef enum logic [1:0] {
    SRC_RST = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2,
    SRC_BRK = 2'd3
  } intSrc_t;

  // T-state indices: T1 is the opcode fetch, T2 the first cycle of every sequence
  localparam int unsigned T_FETCH = 1;
  localparam int unsigned T_ENTRY = 2;

  function automatic vecSel_t vecOf(input intSrc_t s);
    case (s)
      SRC_RST: return VEC_RST;
      SRC_NMI: return VEC_NMI;
      default: return VEC_IRQ;
    endcase
  endfunction

  // Only hardware interrupts acknowledge; reset and BRK do not
  function automatic logic ackSrc(input intSrc_t s);
    return (s == SRC_NMI) || (s == SRC_IRQ);
  endfunction

endpackage

// File: rtl/tstate_int_sequencer_int_arbiter.sv
// NMI edge latch, IRQ masking and lowest-index priority encode, and the NMI hijack decision.
module tstate_int_sequencer_int_arbiter
  import tstate_int_sequencer_pkg::*;
#(
  parameter int unsigned MAX_T      = 7,
  parameter int unsigned N_IRQ      = 1,
  parameter int unsigned INT_CYCLES = 7,
  parameter int unsigned VEC_T      = 5,
  localparam int unsigned T_W       = $clog2(MAX_T + 1),
  localparam int unsigned IRQ_W     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             phi1,
  input  logic             rst,
  input  logic             rdy,
  input  logic             nmi,
  input  logic [N_IRQ-1:0] irq,
  input  logic             i_flag,
  input  seqMode_t         mode,
  input  intSrc_t          src,
  input  logic [T_W-1:0]   tCnt,
  output logic             nmiPend,
  output logic             irqReq_c,
  output logic [IRQ_W-1:0] irqIdx_c,
  output logic             hijack_c
);

  localparam logic [T_W-1:0] T_INT_END = T_W'(INT_CYCLES);
  localparam logic [T_W-1:0] T_VEC     = T_W'(VEC_T);

  logic nmiD;
  logic nmiRise;
  logic nmiClear;

  assign nmiRise  = nmi & ~nmiD;
  assign nmiClear = rdy && (mode == MODE_INTSEQ) && (src == SRC_NMI) && (tCnt == T_INT_END);

  // Edge detect runs regardless of rdy; a new edge beats the end-of-sequence clear
  always_ff @(posedge phi1 or negedge rst) begin
    if (!rst) begin
      nmiD    <= 1'b0;
      nmiPend <= 1'b0;
    end else begin
      nmiD <= nmi;
      if (nmiRise)
        nmiPend <= 1'b1;
      else if (nmiClear)
        nmiPend <= 1'b0;
    end
  end

  assign irqReq_c = (|irq) & ~i_flag;

  always_comb begin
    irqIdx_c = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--)
      if (irq[i]) irqIdx_c = IRQ_W'(i);
  end

  // An edge arriving this cycle counts, so the vector can switch on the very next T-state
  assign hijack_c = rdy && (mode == MODE_INTSEQ) &&
                    ((src == SRC_IRQ) || (src == SRC_BRK)) &&
                    (tCnt <= T_VEC) && (nmiPend | nmiRise);

endmodule

// File: rtl/tstate_int_sequencer.sv
// Per-cycle T-state generator with SYNC strobes and reset/NMI/IRQ/BRK entry sequencing.
module tstate_int_sequencer
  import tstate_int_sequencer_pkg::*;
#(
  parameter int unsigned MAX_T      = 7,
  parameter int unsigned N_IRQ      = 1,
  parameter int unsigned INT_CYCLES = 7,
  parameter int unsigned VEC_T      = 5,
  localparam int unsigned T_W       = $clog2(MAX_T + 1),
  localparam int unsigned IRQ_W     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             phi1,
  input  logic             rst,
  input  logic             rdy,
  input  logic             nmi,
  input  logic [N_IRQ-1:0] irq,
  input  logic             i_flag,
  input  logic             brk_op,
  input  logic [T_W-1:0]   instr_len,
  input  logic             early_end,
  output logic [MAX_T-1:0] t_state,
  output logic             sync,
  output logic             t1now,
  output logic [1:0]       seq_mode,
  output logic [1:0]       vector_sel,
  output logic [IRQ_W-1:0] irq_id,
  output logic             brk_flag,
  output logic             int_ack
);

  localparam logic [T_W-1:0] T_ONE     = T_W'(T_FETCH);
  localparam logic [T_W-1:0] T_TWO     = T_W'(T_ENTRY);
  localparam logic [T_W-1:0] T_MAX     = T_W'(MAX_T);
  localparam logic [T_W-1:0] T_INT_END = T_W'(INT_CYCLES);

  seqMode_t       mode, nxtMode;
  intSrc_t        src, nxtSrc;
  logic [T_W-1:0] tCnt, nxtT;
  logic [T_W-1:0] lenQ, nxtLen;
  logic           nxtBrk;
  logic [IRQ_W-1:0] nxtIrqId;

  logic             nmiPend;
  logic             irqReq_c;
  logic [IRQ_W-1:0] irqIdx_c;
  logic             hijack_c;

  tstate_int_sequencer_int_arbiter #(
    .MAX_T      (MAX_T),
    .N_IRQ      (N_IRQ),
    .INT_CYCLES (INT_CYCLES),
    .VEC_T      (VEC_T)
  ) u_arb (
    .phi1     (phi1),
    .rst      (rst),
    .rdy      (rdy),
    .nmi      (nmi),
    .irq      (irq),
    .i_flag   (i_flag),
    .mode     (mode),
    .src      (src),
    .tCnt     (tCnt),
    .nmiPend  (nmiPend),
    .irqReq_c (irqReq_c),
    .irqIdx_c (irqIdx_c),
    .hijack_c (hijack_c)
  );

  function automatic logic [T_W-1:0] clampLen(input logic [T_W-1:0] len);
    int unsigned l;
    l = 32'(len);
    if (l < T_ENTRY)
      l = T_ENTRY;
    else if (l > MAX_T)
      l = MAX_T;
    return T_W'(l);
  endfunction

  function automatic logic [MAX_T-1:0] tOneHot(input logic [T_W-1:0] t);
    return MAX_T'(1) << (t - T_ONE);
  endfunction

  // Next sequencing state; everything holds while rdy is low
  always_comb begin : nextState
    nxtMode  = mode;
    nxtSrc   = src;
    nxtT     = tCnt;
    nxtLen   = lenQ;
    nxtBrk   = brk_flag;
    nxtIrqId = irq_id;
    if (rdy) begin
      case (mode)
        MODE_FETCH: begin
          nxtT = T_TWO;
          if (nmiPend) begin
            nxtMode = MODE_INTSEQ;
            nxtSrc  = SRC_NMI;
            nxtBrk  = 1'b0;
          end else if (irqReq_c) begin
            nxtMode  = MODE_INTSEQ;
            nxtSrc   = SRC_IRQ;
            nxtBrk   = 1'b0;
            nxtIrqId = irqIdx_c;
          end else if (brk_op) begin
            nxtMode = MODE_INTSEQ;
            nxtSrc  = SRC_BRK;
            nxtBrk  = 1'b1;
          end else begin
            nxtMode = MODE_EXEC;
            nxtLen  = clampLen(instr_len);
          end
        end
        MODE_EXEC: begin
          if (early_end || (tCnt == lenQ) || (tCnt >= T_MAX)) begin
            nxtMode = MODE_FETCH;
            nxtT    = T_ONE;
          end else begin
            nxtT = tCnt + T_ONE;
          end
        end
        default: begin
          if (tCnt >= T_INT_END) begin
            nxtMode = MODE_FETCH;
            nxtT    = T_ONE;
          end else begin
            nxtT = tCnt + T_ONE;
            if (hijack_c) nxtSrc = SRC_NMI;
          end
        end
      endcase
    end
  end

  // State and registered outputs, the latter derived from the next state
  always_ff @(posedge phi1 or negedge rst) begin
    if (!rst) begin
      mode       <= MODE_INTSEQ;
      src        <= SRC_RST;
      tCnt       <= T_TWO;
      lenQ       <= T_TWO;
      t_state    <= tOneHot(T_TWO);
      sync       <= 1'b0;
      t1now      <= 1'b0;
      seq_mode   <= MODE_INTSEQ;
      vector_sel <= VEC_RST;
      irq_id     <= '0;
      brk_flag   <= 1'b0;
      int_ack    <= 1'b0;
    end else begin
      mode       <= nxtMode;
      src        <= nxtSrc;
      tCnt       <= nxtT;
      lenQ       <= nxtLen;
      t_state    <= tOneHot(nxtT);
      sync       <= (nxtMode == MODE_FETCH);
      t1now      <= (nxtMode == MODE_FETCH);
      seq_mode   <= nxtMode;
      vector_sel <= vecOf(nxtSrc);
      irq_id     <= nxtIrqId;
      brk_flag   <= nxtBrk;
      int_ack    <= (nxtMode == MODE_INTSEQ) && (nxtT == T_INT_END) && ackSrc(nxtSrc);
    end
  end

endmodule
